// File: rtl/booth_r4_mul_if.sv
// Handshake bundle for booth_r4_mul: operand channel in, product channel out.
// The slave modport is the multiplier's view; the master modport is the producer/consumer side.
interface booth_r4_mul_if #(
  parameter int unsigned A_W   = 8,
  parameter int unsigned B_W   = 8,
  parameter int unsigned OUT_W = A_W + B_W
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic             in_signed_i;
  logic [A_W-1:0]   in_A_i;
  logic [B_W-1:0]   in_B_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [OUT_W-1:0] mult_out_o;
  logic             ovf_o;
  logic             busy_o;

  modport slave (
    input  in_valid_i,
    input  in_signed_i,
    input  in_A_i,
    input  in_B_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output mult_out_o,
    output ovf_o,
    output busy_o
  );

  modport master (
    output in_valid_i,
    output in_signed_i,
    output in_A_i,
    output in_B_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  mult_out_o,
    input  ovf_o,
    input  busy_o
  );
endinterface

// File: rtl/booth_r4_mul.sv
// Radix-4 Booth sequential multiplier, one Booth digit per cycle, valid/ready on both sides.
// Optional feature macro: BOOTH_R4_EARLY_TERM_EN - finish as soon as every remaining digit is 0.
module booth_r4_mul #(
  parameter int unsigned A_W   = 8,
  parameter int unsigned B_W   = 8,
  parameter int unsigned OUT_W = A_W + B_W
) (
  input logic           clk,
  input logic           rst,
  booth_r4_mul_if.slave bus
);
  localparam int unsigned NDIG = (B_W + 2) / 2;
  // The full product fits in A_W+B_W bits, so modular accumulation at that width is exact.
  localparam int unsigned PW   = A_W + B_W;
  // Extended multiplier: 2*NDIG bits plus the implicit 0 below bit 0.
  localparam int unsigned BX   = 2 * NDIG + 1;
  localparam int unsigned K_W  = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  a_q, a_d;
  logic [BX-1:0]  b_q, b_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic [K_W-1:0] k_q, k_d;
  logic           sgn_q, sgn_d;

  logic [PW-1:0]  a_ext;
  logic [BX-1:0]  b_ext;
  logic [PW-1:0]  pp;
  logic           accept;
  logic           rest_zero;
  logic           last_digit;
  logic           ovf_raw;

  // Operand extension: sign or zero fill according to the requested mode.
  always_comb begin
    a_ext = {{(PW - A_W){bus.in_signed_i & bus.in_A_i[A_W-1]}}, bus.in_A_i};
    b_ext = {{(BX - 1 - B_W){bus.in_signed_i & bus.in_B_i[B_W-1]}}, bus.in_B_i, 1'b0};
  end

  // Booth digit decode of the current 3-bit window into a partial product.
  always_comb begin
    case (b_q[2:0])
      3'b001, 3'b010: pp = a_q;
      3'b011:         pp = a_q << 1;
      3'b100:         pp = -(a_q << 1);
      3'b101, 3'b110: pp = -a_q;
      default:        pp = '0;
    endcase
  end

  // Remaining multiplier bits all equal the window top -> all later digits are zero.
`ifdef BOOTH_R4_EARLY_TERM_EN
  assign rest_zero = (b_q[BX-1:2] == {(BX - 2){b_q[2]}});
`else
  assign rest_zero = 1'b0;
`endif

  assign last_digit = (k_q == K_W'(NDIG - 1)) || rest_zero;

  // Handshake outputs; ready is withheld while reset is asserted.
  always_comb begin
    bus.in_ready_o  = 1'b0;
    bus.out_valid_o = 1'b0;
    bus.busy_o      = 1'b0;
    unique case (state_q)
      StIdle:  bus.in_ready_o = ~rst;
      StCalc:  bus.busy_o     = 1'b1;
      StDone: begin
        bus.out_valid_o = 1'b1;
        bus.in_ready_o  = bus.out_ready_i;
      end
      default: ;
    endcase
  end

  assign accept = bus.in_valid_i & bus.in_ready_o;

  // Next-state: load on accept, one Booth step per CALC cycle, release on output handshake.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    k_d     = k_q;
    sgn_d   = sgn_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StCalc;
      end
      StCalc: begin
        acc_d = acc_q + pp;
        a_d   = a_q << 2;
        b_d   = {{2{b_q[BX-1]}}, b_q[BX-1:2]};
        k_d   = k_q + K_W'(1);
        if (last_digit) state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready_i) state_d = accept ? StCalc : StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      a_d   = a_ext;
      b_d   = b_ext;
      acc_d = '0;
      k_d   = '0;
      sgn_d = bus.in_signed_i;
    end
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      sgn_q   <= sgn_d;
    end
  end

  // Overflow: discarded upper bits must be a pure sign (signed) or zero (unsigned) extension.
  if (OUT_W < PW) begin : g_ovf
    always_comb begin
      if (sgn_q) ovf_raw = (acc_q[PW-1:OUT_W] != {(PW - OUT_W){acc_q[OUT_W-1]}});
      else       ovf_raw = (acc_q[PW-1:OUT_W] != '0);
    end
  end else begin : g_no_ovf
    logic unused_sgn;
    assign unused_sgn = sgn_q;
    assign ovf_raw    = 1'b0;
  end

  assign bus.mult_out_o = acc_q[OUT_W-1:0];
  assign bus.ovf_o      = (state_q == StDone) & ovf_raw;
endmodule

// File: tb/tb_booth_r4_mul.sv
// Scoreboard bench for booth_r4_mul: full-width instance plus an 8-bit truncating instance.
module tb_booth_r4_mul;
  typedef struct {
    logic [15:0] p;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_r4_mul_if #(.A_W(8), .B_W(8), .OUT_W(16)) bus ();
  booth_r4_mul_if #(.A_W(8), .B_W(8), .OUT_W(8))  bus8 ();

  booth_r4_mul #(.A_W(8), .B_W(8), .OUT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  booth_r4_mul #(.A_W(8), .B_W(8), .OUT_W(8))  u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

  exp_t exp_q[$];
  exp_t exp8_q[$];
  exp_t mon_e;
  exp_t mon8_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int exp_lat(input int lat_et);
`ifdef BOOTH_R4_EARLY_TERM_EN
    return lat_et;
`else
    return 5 + 0 * lat_et;
`endif
  endfunction

  // Monitor for the full-width instance.
  always @(negedge clk) begin
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {16'h0, bus.mult_out_o}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("product", {16'h0, bus.mult_out_o}, {16'h0, mon_e.p});
        check("ovf", {31'h0, bus.ovf_o}, {31'h0, mon_e.ovf});
      end
    end
  end

  // Monitor for the truncating instance.
  always @(negedge clk) begin
    if (!rst && bus8.out_valid_o && bus8.out_ready_i) begin
      if (exp8_q.size() == 0) begin
        check("unexpected_result8", {24'h0, bus8.mult_out_o}, 32'hFFFF_FFFF);
      end else begin
        mon8_e = exp8_q.pop_front();
        check("product8", {24'h0, bus8.mult_out_o}, {24'h0, mon8_e.p[7:0]});
        check("ovf8", {31'h0, bus8.ovf_o}, {31'h0, mon8_e.ovf});
      end
    end
  end

  task automatic wait_in_ready();
    int n = 0;
    while (!bus.in_ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_wait", {31'h0, bus.in_ready_o}, 32'h1);
  endtask

  task automatic wait_out_valid(input int lat_et);
    int n = 0;
    while (!bus.out_valid_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, exp_lat(lat_et));
  endtask

  task automatic mul16(input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] p, input int lat_et);
    exp_t e;
    @(posedge clk); #1;
    bus.in_valid_i  = 1'b1;
    bus.in_signed_i = s;
    bus.in_A_i      = a;
    bus.in_B_i      = b;
    wait_in_ready();
    e.p = p; e.ovf = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    wait_out_valid(lat_et);
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    check("valid_drop", {31'h0, bus.out_valid_o}, 32'h0);
  endtask

  task automatic mul8(input logic s, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] p, input logic ovf);
    exp_t e;
    int   n = 0;
    @(posedge clk); #1;
    bus8.in_valid_i  = 1'b1;
    bus8.in_signed_i = s;
    bus8.in_A_i      = a;
    bus8.in_B_i      = b;
    while (!bus8.in_ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    e.p = {8'h0, p}; e.ovf = ovf;
    exp8_q.push_back(e);
    @(posedge clk); #1;
    bus8.in_valid_i = 1'b0;
    n = 0;
    while (exp8_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("dut8_result_seen", exp8_q.size(), 0);
  endtask

  initial begin
    bus.in_valid_i   = 1'b0;
    bus.in_signed_i  = 1'b0;
    bus.in_A_i       = '0;
    bus.in_B_i       = '0;
    bus.out_ready_i  = 1'b0;
    bus8.in_valid_i  = 1'b0;
    bus8.in_signed_i = 1'b0;
    bus8.in_A_i      = '0;
    bus8.in_B_i      = '0;
    bus8.out_ready_i = 1'b1;

    // Reset values.
    #12;
    check("rst_in_ready", {31'h0, bus.in_ready_o}, 32'h0);
    check("rst_out_valid", {31'h0, bus.out_valid_o}, 32'h0);
    check("rst_mult_out", {16'h0, bus.mult_out_o}, 32'h0);
    check("rst_ovf", {31'h0, bus.ovf_o}, 32'h0);
    check("rst_busy", {31'h0, bus.busy_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check("post_rst_in_ready", {31'h0, bus.in_ready_o}, 32'h1);

    // Signed corners.
    mul16(1'b1, 8'h80, 8'h80, 16'h4000, 4);
    mul16(1'b1, 8'h80, 8'h7F, 16'hC080, 4);
    mul16(1'b1, 8'hFF, 8'h01, 16'hFFFF, 1);
    mul16(1'b1, 8'h01, 8'hFF, 16'hFFFF, 1);
    mul16(1'b1, 8'hFD, 8'h05, 16'hFFF1, 2);
    mul16(1'b1, 8'h55, 8'h00, 16'h0000, 1);

    // Unsigned corners.
    mul16(1'b0, 8'hFF, 8'hFF, 16'hFE01, 5);
    mul16(1'b0, 8'hC8, 8'h03, 16'h0258, 2);
    mul16(1'b0, 8'h00, 8'hFF, 16'h0000, 5);

    // Back-pressure: hold 7x9 for 10 cycles, then hand off straight into 3x4.
    @(posedge clk); #1;
    bus.in_valid_i  = 1'b1;
    bus.in_signed_i = 1'b0;
    bus.in_A_i      = 8'd7;
    bus.in_B_i      = 8'd9;
    wait_in_ready();
    mon_e.p = 16'd63; mon_e.ovf = 1'b0;
    exp_q.push_back(mon_e);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    wait_out_valid(3);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {16'h0, bus.mult_out_o}, 32'd63);
      check("bp_in_ready", {31'h0, bus.in_ready_o}, 32'h0);
      check("bp_valid", {31'h0, bus.out_valid_o}, 32'h1);
      @(posedge clk); #1;
    end
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.in_A_i      = 8'd3;
    bus.in_B_i      = 8'd4;
    mon_e.p = 16'd12; mon_e.ovf = 1'b0;
    exp_q.push_back(mon_e);
    #1 check("bp_pass_ready", {31'h0, bus.in_ready_o}, 32'h1);
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b0;
    check("bp_no_idle", {31'h0, bus.busy_o}, 32'h1);
    wait_out_valid(2);
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;

    // Reset two cycles into 5x5: everything returns to reset values without a clock edge.
    @(posedge clk); #1;
    bus.in_valid_i = 1'b1;
    bus.in_A_i     = 8'd5;
    bus.in_B_i     = 8'd5;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'h0, bus.busy_o}, 32'h0);
    check("mid_rst_out_valid", {31'h0, bus.out_valid_o}, 32'h0);
    check("mid_rst_in_ready", {31'h0, bus.in_ready_o}, 32'h0);
    check("mid_rst_mult_out", {16'h0, bus.mult_out_o}, 32'h0);
    check("mid_rst_ovf", {31'h0, bus.ovf_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (bus.out_valid_o) seen = 1'b1;
      end
      check("no_pulse_after_reset", {31'h0, seen}, 32'h0);
    end
    bus.out_ready_i = 1'b0;
    mul16(1'b0, 8'd6, 8'd6, 16'd36, 2);

    // Truncation on the 8-bit instance.
    mul8(1'b0, 8'd16, 8'd16, 8'h00, 1'b1);
    mul8(1'b0, 8'd15, 8'd17, 8'hFF, 1'b0);
    mul8(1'b1, 8'hF8, 8'd16, 8'h80, 1'b0);
    mul8(1'b1, 8'd16, 8'd16, 8'h00, 1'b1);

    repeat (5) @(posedge clk);
    #1 check("scoreboard_drained", exp_q.size() + exp8_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
